// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-CTR AXI4-Lite register file: byte offsets,
// word counts, response codes, FSM states and the address decoder.
package aes_ctr_pkg;

    localparam logic [7:0] START     = 8'h00;
    localparam logic [7:0] PT_BASE   = 8'h04;
    localparam logic [7:0] KEY0_BASE = 8'h14;
    localparam logic [7:0] DONE      = 8'h2C;
    localparam logic [7:0] CT_BASE   = 8'h30;
    localparam logic [7:0] ST_BASE   = 8'h40;
    localparam logic [7:0] KEY1_BASE = 8'h50;
    localparam logic [7:0] KEY2_BASE = 8'h68;
    localparam logic [7:0] KEY_SEL   = 8'h80;

    localparam int PT_WORDS  = 4;
    localparam int CT_WORDS  = 4;
    localparam int ST_WORDS  = 4;
    localparam int KEY_WORDS = 6;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    typedef enum logic [3:0] {
        F_NONE, F_START, F_PT, F_KEY0, F_DONE, F_CT, F_ST, F_KEY1, F_KEY2, F_KEY_SEL
    } field_e;

    typedef struct packed {
        field_e     field;
        logic [2:0] word;
    } reg_dec_t;

    function automatic logic in_range(input logic [7:0] a, input logic [7:0] base, input int words);
        return (a >= base) && ({1'b0, a} < ({1'b0, base} + 9'(4 * words)));
    endfunction

    // Unaligned or unmapped byte addresses decode to F_NONE.
    function automatic reg_dec_t decode(input logic [7:0] a);
        reg_dec_t   d;
        logic [7:0] base;
        d.field = F_NONE;
        base    = '0;
        if (a[1:0] == 2'b00) begin
            if (a == START)                            d.field = F_START;
            else if (a == DONE)                        d.field = F_DONE;
            else if (a == KEY_SEL)                     d.field = F_KEY_SEL;
            else if (in_range(a, PT_BASE, PT_WORDS))   begin d.field = F_PT;   base = PT_BASE;   end
            else if (in_range(a, KEY0_BASE, KEY_WORDS)) begin d.field = F_KEY0; base = KEY0_BASE; end
            else if (in_range(a, CT_BASE, CT_WORDS))   begin d.field = F_CT;   base = CT_BASE;   end
            else if (in_range(a, ST_BASE, ST_WORDS))   begin d.field = F_ST;   base = ST_BASE;   end
            else if (in_range(a, KEY1_BASE, KEY_WORDS)) begin d.field = F_KEY1; base = KEY1_BASE; end
            else if (in_range(a, KEY2_BASE, KEY_WORDS)) begin d.field = F_KEY2; base = KEY2_BASE; end
        end
        d.word = 3'((a - base) >> 2);
        return d;
    endfunction

endpackage

// File: rtl/aes_ctr_axil_regs_wstrb_merge.sv
// Byte-strobe merge of a 32-bit write onto the current register word.
module axil_wstrb_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

endmodule

// File: rtl/aes_ctr_axil_regs.sv
// AXI4-Lite register file for the AES-CTR core (base 0x44C0_0000).
// Optional build macro AES_CTR_AUTO_INC_EN: ST increments on every core_done.
module aes_ctr_axil_regs
    import aes_ctr_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int NUM_KEYS = 3,
    parameter int KEY_BITS = 192
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                core_start,
    output logic [127:0]        core_pt,
    output logic [127:0]        core_st,
    output logic [KEY_BITS-1:0] core_key,
    input  logic                core_busy,
    input  logic                core_done,
    input  logic [127:0]        core_ct
);

    localparam int KW  = KEY_BITS / 32;
    localparam int KSW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    // state  | meaning
    // W_IDLE | waiting for AW and W together
    // W_RESP | bvalid high until bready
    // R_IDLE | arready high (once out of reset)
    // R_DATA | rvalid high, rdata/rresp held until rready
    wr_state_e w_state, w_next;
    rd_state_e r_state, r_next;

    logic           start_bit, done_flag, rst_done;
    logic [31:0]    pt_q  [PT_WORDS];
    logic [31:0]    st_q  [ST_WORDS];
    logic [31:0]    ct_q  [CT_WORDS];
    logic [31:0]    key_q [NUM_KEYS][KW];
    logic [KSW-1:0] key_sel_q;
    axi_resp_e      bresp_q, rresp_q;
    logic [31:0]    rdata_q;

    reg_dec_t    wr_dec, rd_dec;
    logic [31:0] wr_old, wr_merged, rd_word_v;
    logic        wr_fire, wr_err, wr_ok, rd_fire, start_rise;
    logic        unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    function automatic logic [31:0] word_of(input reg_dec_t d);
        logic [31:0] v;
        v = '0;
        case (d.field)
            F_START:   v = {30'b0, core_busy, start_bit};
            F_PT:      v = pt_q[d.word[1:0]];
            F_KEY0:    v = key_q[0][d.word];
            F_DONE:    v = {31'b0, done_flag};
            F_CT:      v = ct_q[d.word[1:0]];
            F_ST:      v = st_q[d.word[1:0]];
            F_KEY1:    v = key_q[1][d.word];
            F_KEY2:    v = key_q[2][d.word];
            F_KEY_SEL: v = 32'(key_sel_q);
            default:   v = '0;
        endcase
        return v;
    endfunction

    assign wr_dec    = decode(8'(s_axi_awaddr));
    assign rd_dec    = decode(8'(s_axi_araddr));
    assign wr_old    = word_of(wr_dec);
    assign rd_word_v = word_of(rd_dec);

    axil_wstrb_merge u_merge (
        .old_word (wr_old),
        .wdata    (s_axi_wdata),
        .wstrb    (s_axi_wstrb),
        .merged   (wr_merged)
    );

    assign wr_fire    = s_axi_awready && s_axi_wready;
    assign wr_err     = (wr_dec.field inside {F_NONE, F_DONE, F_CT}) ||
                        ((wr_dec.field == F_KEY_SEL) && (wr_merged >= 32'(NUM_KEYS)));
    assign wr_ok      = wr_fire && !wr_err;
    assign start_rise = wr_ok && (wr_dec.field == F_START) && wr_merged[0] && !start_bit;
    assign rd_fire    = s_axi_arvalid && s_axi_arready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            rst_done <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            rst_done <= 1'b1;
            if (wr_fire) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (rd_fire) begin
                rdata_q <= rd_word_v;
                rresp_q <= (rd_dec.field == F_NONE) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        case (w_state)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                w_next        = W_RESP;
            end
            W_RESP: if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        case (r_state)
            R_IDLE: if (rst_done) begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_next = R_DATA;
            end
            R_DATA: if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign s_axi_bvalid = (w_state == W_RESP);
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = (r_state == R_DATA);
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;

`ifdef AES_CTR_AUTO_INC_EN
    logic [127:0] st_inc;
    assign st_inc = core_st + 128'd1;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_bit  <= 1'b0;
            done_flag  <= 1'b0;
            core_start <= 1'b0;
            key_sel_q  <= '0;
            for (int n = 0; n < PT_WORDS; n++) pt_q[n] <= '0;
            for (int n = 0; n < ST_WORDS; n++) st_q[n] <= '0;
            for (int n = 0; n < CT_WORDS; n++) ct_q[n] <= '0;
            for (int k = 0; k < NUM_KEYS; k++)
                for (int n = 0; n < KW; n++) key_q[k][n] <= '0;
        end else begin
            core_start <= start_rise;
            if (wr_ok) begin
                case (wr_dec.field)
                    F_START:   start_bit <= wr_merged[0];
                    F_PT:      pt_q[wr_dec.word[1:0]] <= wr_merged;
                    F_ST:      st_q[wr_dec.word[1:0]] <= wr_merged;
                    F_KEY0:    key_q[0][wr_dec.word] <= wr_merged;
                    F_KEY1:    key_q[1][wr_dec.word] <= wr_merged;
                    F_KEY2:    key_q[2][wr_dec.word] <= wr_merged;
                    F_KEY_SEL: key_sel_q <= wr_merged[KSW-1:0];
                    default: ;
                endcase
            end
            // Placed after the bus write so the core-side update takes priority.
            if (core_done) begin
                for (int n = 0; n < CT_WORDS; n++) ct_q[n] <= core_ct[32*n +: 32];
`ifdef AES_CTR_AUTO_INC_EN
                for (int n = 0; n < ST_WORDS; n++) st_q[n] <= st_inc[32*n +: 32];
`endif
            end
            if (core_start)     done_flag <= 1'b0;
            else if (core_done) done_flag <= 1'b1;
        end
    end

    always_comb begin
        core_pt  = '0;
        core_st  = '0;
        core_key = '0;
        for (int n = 0; n < PT_WORDS; n++) core_pt[32*n +: 32] = pt_q[n];
        for (int n = 0; n < ST_WORDS; n++) core_st[32*n +: 32] = st_q[n];
        for (int n = 0; n < KW; n++)       core_key[32*n +: 32] = key_q[key_sel_q][n];
    end

endmodule

// File: tb/tb_aes_ctr_axil_regs.sv
// Self-checking bench for aes_ctr_axil_regs against a word-map reference model.
module tb_aes_ctr_axil_regs;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [7:0]   s_axi_awaddr;
    logic [2:0]   s_axi_awprot;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [7:0]   s_axi_araddr;
    logic [2:0]   s_axi_arprot;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic         core_start;
    logic [127:0] core_pt;
    logic [127:0] core_st;
    logic [191:0] core_key;
    logic         core_busy;
    logic         core_done;
    logic [127:0] core_ct;

    aes_ctr_axil_regs #(.ADDR_W(8), .NUM_KEYS(3), .KEY_BITS(192)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .core_start(core_start), .core_pt(core_pt), .core_st(core_st), .core_key(core_key),
        .core_busy(core_busy), .core_done(core_done), .core_ct(core_ct)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    int start_pulses = 0;

    always @(posedge aclk) if (core_start === 1'b1) start_pulses++;

    // Reference model: one 32-bit slot per word address (index = byte address / 4).
    bit [31:0] m_word [0:32];
    bit        m_start;
    bit        m_done;
    int        m_pulses = 0;

    function automatic void m_clear();
        for (int i = 0; i <= 32; i++) m_word[i] = 0;
        m_start = 0;
        m_done  = 0;
    endfunction

    function automatic void m_read(input int a, output logic [31:0] d, output logic [1:0] r);
        d = 0;
        r = 2'b00;
        if ((a % 4) != 0 || a > 'h80) r = 2'b10;
        else if (a == 'h00) d = {30'b0, core_busy, m_start};
        else if (a == 'h2C) d = {31'b0, m_done};
        else d = m_word[a / 4];
    endfunction

    function automatic void m_write(input int a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        logic [31:0] old, merged;
        r = 2'b10;
        if ((a % 4) != 0 || a > 'h80 || a == 'h2C || (a >= 'h30 && a <= 'h3C)) return;
        old = (a == 0) ? {31'b0, m_start} : m_word[a / 4];
        merged = old;
        for (int b = 0; b < 4; b++) if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
        if (a == 'h80 && merged >= 3) return;
        r = 2'b00;
        if (a == 0) begin
            if (merged[0] && !m_start) begin
                m_pulses++;
                m_done = 0;
            end
            m_start = merged[0];
        end else begin
            m_word[a / 4] = merged;
        end
    endfunction

    function automatic void m_core_done(input logic [127:0] ct);
        m_done = 1;
        for (int n = 0; n < 4; n++) m_word[12 + n] = ct[32*n +: 32];
`ifdef AES_CTR_AUTO_INC_EN
        {m_word[19], m_word[18], m_word[17], m_word[16]} =
            {m_word[19], m_word[18], m_word[17], m_word[16]} + 128'd1;
`endif
    endfunction

    function automatic logic [191:0] m_key();
        logic [191:0] k;
        int kb;
        kb = (m_word[32] == 0) ? 5 : (m_word[32] == 1) ? 20 : 26;
        for (int n = 0; n < 6; n++) k[32*n +: 32] = m_word[kb + n];
        return k;
    endfunction

    function automatic logic [127:0] m_vec(input int base);
        return {m_word[base + 3], m_word[base + 2], m_word[base + 1], m_word[base]};
    endfunction

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        int   n;
        logic hs;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin
            #1 hs = s_axi_awready && s_axi_wready;
            @(posedge aclk); #1;
            n++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        resp = 2'bxx;
        if (!hs) begin
            checks++; failures++;
            $display("FAIL aw_handshake_timeout addr=%h", a);
            return;
        end
        s_axi_bready = 1; n = 0;
        while (s_axi_bvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        if (s_axi_bvalid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL bvalid_timeout addr=%h", a);
            s_axi_bready = 0;
            return;
        end
        resp = s_axi_bresp;
        @(posedge aclk); #1;
        s_axi_bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int   n;
        logic hs;
        s_axi_araddr = a; s_axi_arvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin
            #1 hs = s_axi_arready;
            @(posedge aclk); #1;
            n++;
        end
        s_axi_arvalid = 0;
        d = 'x; resp = 2'bxx;
        if (!hs) begin
            checks++; failures++;
            $display("FAIL ar_handshake_timeout addr=%h", a);
            return;
        end
        s_axi_rready = 1; n = 0;
        while (s_axi_rvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        if (s_axi_rvalid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL rvalid_timeout addr=%h", a);
            s_axi_rready = 0;
            return;
        end
        d = s_axi_rdata; resp = s_axi_rresp;
        @(posedge aclk); #1;
        s_axi_rready = 0;
    endtask

    task automatic pulse_done(input logic [127:0] ct);
        core_ct = ct; core_done = 1;
        @(posedge aclk); #1;
        core_done = 0;
    endtask

    task automatic check_read(input string name, input int a);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        axi_read(8'(a), d, r);
        m_read(a, ed, er);
        checks++;
        if (d !== ed || r !== er) begin
            failures++;
            $display("FAIL %s addr=%h got data=%h resp=%b expected data=%h resp=%b", name, a, d, r, ed, er);
        end
    endtask

    task automatic check_write(input string name, input int a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r, er;
        axi_write(8'(a), d, s, r);
        m_write(a, d, s, er);
        checks++;
        if (r !== er) begin
            failures++;
            $display("FAIL %s addr=%h got bresp=%b expected %b", name, a, r, er);
        end
    endtask

    task automatic check_core_outputs(input string name);
        checks++;
        if (core_key !== m_key() || core_pt !== m_vec(1) || core_st !== m_vec(16)) begin
            failures++;
            $display("FAIL %s core_key=%h/%h core_pt=%h/%h core_st=%h/%h (got/expected)",
                     name, core_key, m_key(), core_pt, m_vec(1), core_st, m_vec(16));
        end
    endtask

    task automatic test_reset();
        logic [14:0] got;
        got = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
               core_start, s_axi_bresp, s_axi_rresp, |s_axi_rdata, |core_key, |core_pt, |core_st, 1'b0};
        checks++;
        if (got !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected all zero", got);
        end
        @(posedge aclk); #1 aresetn = 1;
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if (s_axi_arready !== 1'b1) begin
            failures++;
            $display("FAIL arready_after_reset got=%b expected 1", s_axi_arready);
        end
        check_read("reset_start", 'h00);
        check_read("reset_keysel", 'h80);
    endtask

    task automatic test_key0();
        logic [31:0] kw [6] = '{32'h28aed2a6, 32'h2b7e1516, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
        check_write("keysel0_wr", 'h80, 0, 4'hF);
        for (int n = 0; n < 6; n++) check_write("key0_wr", 'h14 + 4*n, kw[n], 4'hF);
        checks++;
        if (core_key !== 192'h2b7e151628aed2a6abf7158809cf4f3c2b7e151628aed2a6) begin
            failures++;
            $display("FAIL key0_vector got=%h expected=2b7e151628aed2a6abf7158809cf4f3c2b7e151628aed2a6", core_key);
        end
        for (int n = 0; n < 6; n++) check_read("key0_rd", 'h14 + 4*n);
    endtask

    task automatic test_st();
        logic [31:0] sw [4] = '{32'he0370734, 32'h313198a2, 32'h885a308d, 32'h3243f6a8};
        for (int n = 0; n < 4; n++) check_write("st_wr", 'h40 + 4*n, sw[n], 4'hF);
        checks++;
        if (core_st !== 128'h3243f6a8885a308d313198a2e0370734) begin
            failures++;
            $display("FAIL st_vector got=%h expected=3243f6a8885a308d313198a2e0370734", core_st);
        end
    endtask

    task automatic test_start_done();
        int   n;
        logic hs;
        logic [1:0] r, er;
        check_write("start0", 'h00, 0, 4'hF);
        check_write("start1", 'h00, 1, 4'hF);
        check_write("start0b", 'h00, 0, 4'hF);
        repeat (2) @(posedge aclk); #1;
        checks++;
        if (start_pulses !== m_pulses || m_pulses !== 1) begin
            failures++;
            $display("FAIL start_pulse_count got=%0d expected=%0d", start_pulses, m_pulses);
        end
        check_read("done_before", 'h2C);
        pulse_done(128'h3925841d02dc09fbdc118597196a0b32);
        m_core_done(128'h3925841d02dc09fbdc118597196a0b32);
        check_read("done_after", 'h2C);
        for (int i = 0; i < 4; i++) check_read("ct_rd", 'h30 + 4*i);
        // Already 1: a second write of 1 must not pulse.
        check_write("start1a", 'h00, 1, 4'hF);
        check_write("start1b", 'h00, 1, 4'hF);
        repeat (2) @(posedge aclk); #1;
        checks++;
        if (start_pulses !== m_pulses) begin
            failures++;
            $display("FAIL start_repeat_pulse got=%0d expected=%0d", start_pulses, m_pulses);
        end
        check_read("done_cleared", 'h2C);
        // Start pulse and core_done on the same cycle.
        check_write("start0c", 'h00, 0, 4'hF);
        s_axi_awaddr = 0; s_axi_wdata = 1; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin
            #1 hs = s_axi_awready && s_axi_wready;
            @(posedge aclk); #1;
            n++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        core_ct = 128'h0123456789abcdeffedcba9876543210; core_done = 1;
        s_axi_bready = 1;
        r = s_axi_bresp;
        @(posedge aclk); #1;
        core_done = 0; s_axi_bready = 0;
        m_write(0, 1, 4'hF, er);
        m_core_done(128'h0123456789abcdeffedcba9876543210);
        m_done = 0;
        checks++;
        if (!hs || r !== er) begin
            failures++;
            $display("FAIL start_done_collide_bresp got=%b expected=%b hs=%b", r, er, hs);
        end
        check_read("collide_done", 'h2C);
        check_read("collide_ct0", 'h30);
        check_read("collide_ct3", 'h3C);
    endtask

    task automatic test_slverr();
        check_write("slverr_ct", 'h30, 32'hdeadbeef, 4'hF);
        check_write("slverr_oob", 'h84, 32'hdeadbeef, 4'hF);
        check_write("slverr_keysel", 'h80, 3, 4'hF);
        check_write("slverr_done", 'h2C, 0, 4'hF);
        check_write("slverr_unaligned", 'h06, 32'h11111111, 4'hF);
        check_read("slverr_ct_rd", 'h30);
        check_read("slverr_keysel_rd", 'h80);
        check_read("slverr_pt_rd", 'h04);
        check_read("slverr_oob_rd", 'h84);
        check_core_outputs("slverr_core");
    endtask

    task automatic test_stall();
        logic [31:0] d0, ed;
        logic [1:0]  b0, eb, er;
        int   n;
        logic hs;
        d0 = $urandom;
        s_axi_awaddr = 8'h04; s_axi_wdata = d0; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin #1 hs = s_axi_awready; @(posedge aclk); #1; n++; end
        m_write('h04, d0, 4'hF, eb);
        s_axi_awaddr = 8'h08; s_axi_wdata = ~d0;
        b0 = s_axi_bresp;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== eb || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
                failures++;
                $display("FAIL b_stall cycle=%0d bvalid=%b bresp=%b awready=%b wready=%b expected 1,%b,0,0",
                         i, s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, eb);
            end
            @(posedge aclk); #1;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_bready = 1;
        @(posedge aclk); #1;
        s_axi_bready = 0;
        checks++;
        if (s_axi_bvalid !== 1'b0 || b0 !== eb) begin
            failures++;
            $display("FAIL b_release bvalid=%b bresp=%b expected 0,%b", s_axi_bvalid, b0, eb);
        end
        s_axi_araddr = 8'h04; s_axi_arvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin #1 hs = s_axi_arready; @(posedge aclk); #1; n++; end
        m_read('h04, ed, er);
        s_axi_araddr = 8'h2C;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== ed || s_axi_rresp !== er || s_axi_arready !== 1'b0) begin
                failures++;
                $display("FAIL r_stall cycle=%0d rvalid=%b rdata=%h rresp=%b arready=%b expected 1,%h,%b,0",
                         i, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready, ed, er);
            end
            @(posedge aclk); #1;
        end
        s_axi_arvalid = 0;
        s_axi_rready = 1;
        @(posedge aclk); #1;
        s_axi_rready = 0;
        checks++;
        if (s_axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL r_release rvalid=%b expected 0", s_axi_rvalid);
        end
        check_read("stall_pt1_untouched", 'h08);
    endtask

    task automatic test_random();
        int          a;
        logic [31:0] d;
        for (int i = 0; i < 60; i++) begin
            core_busy = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 34) * 4;
            if ($urandom_range(0, 9) == 0) a += $urandom_range(1, 3);
            if ($urandom_range(0, 9) < 6) begin
                d = (a == 'h80) ? 32'($urandom_range(0, 4)) : $urandom;
                check_write("rand_wr", a, d, 4'($urandom_range(0, 15)));
            end else begin
                check_read("rand_rd", a);
            end
        end
        core_busy = 0;
        for (int w = 0; w <= 32; w++) check_read("rand_sweep", w * 4);
        check_core_outputs("rand_core");
        repeat (2) @(posedge aclk); #1;
        checks++;
        if (start_pulses !== m_pulses) begin
            failures++;
            $display("FAIL rand_start_pulses got=%0d expected=%0d", start_pulses, m_pulses);
        end
    endtask

    task automatic test_auto_inc();
        logic [127:0] exp_st;
        for (int n = 0; n < 4; n++) check_write("allones_wr", 'h40 + 4*n, 32'hFFFF_FFFF, 4'hF);
        pulse_done(128'hA5A5);
        m_core_done(128'hA5A5);
`ifdef AES_CTR_AUTO_INC_EN
        exp_st = 128'd0;
`else
        exp_st = {128{1'b1}};
`endif
        checks++;
        if (core_st !== exp_st) begin
            failures++;
            $display("FAIL st_after_done got=%h expected=%h", core_st, exp_st);
        end
        for (int n = 0; n < 4; n++) check_read("st_after_done_rd", 'h40 + 4*n);
    endtask

    task automatic test_reset_mid();
        int   n;
        logic hs;
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h5555_aaaa; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin #1 hs = s_axi_awready; @(posedge aclk); #1; n++; end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 8'h04; s_axi_arvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin #1 hs = s_axi_arready; @(posedge aclk); #1; n++; end
        s_axi_arvalid = 0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL pending_before_reset bvalid=%b rvalid=%b expected 1,1", s_axi_bvalid, s_axi_rvalid);
        end
        #2 aresetn = 0;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || core_pt !== 128'd0 || core_key !== 192'd0) begin
            failures++;
            $display("FAIL reset_mid bvalid=%b rvalid=%b core_pt=%h core_key=%h expected all zero",
                     s_axi_bvalid, s_axi_rvalid, core_pt, core_key);
        end
        m_clear();
        @(posedge aclk); #1 aresetn = 1;
        repeat (2) @(posedge aclk); #1;
        check_read("post_reset_pt0", 'h04);
        check_read("post_reset_st0", 'h40);
    endtask

    initial begin
        aresetn = 0;
        s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0;
        s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_araddr = 0; s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        core_busy = 0; core_done = 0; core_ct = 0;
        m_clear();
        repeat (3) @(posedge aclk);
        #1;
        test_reset();
        test_key0();
        test_st();
        test_start_done();
        test_slverr();
        test_stall();
        test_random();
        test_auto_inc();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
